// File: rtl/cond_unit_pkg.sv
// Shared condition-code definitions: flag bit positions, jXX/cmovXX function codes, reset value.
// Also used by the ALU so both sides agree on {ZF,SF,OF} ordering.
package cond_unit_pkg;

    localparam int          CC_W     = 3;
    localparam logic [2:0]  CC_RESET = 3'b100;

    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;

    typedef enum logic [3:0] {
        C_YES = 4'd0,
        C_LE  = 4'd1,
        C_L   = 4'd2,
        C_E   = 4'd3,
        C_NE  = 4'd4,
        C_GE  = 4'd5,
        C_G   = 4'd6
    } cond_fn_e;

endpackage

// File: rtl/cond_eval.sv
// Pure combinational Y86-64 condition function: (cc, ifun) -> cnd.
// Unknown function codes evaluate to 0.
module cond_eval
    import cond_unit_pkg::*;
(
    input  logic [CC_W-1:0] i_cc,
    input  logic [3:0]      i_ifun,
    output logic            o_cnd
);

    logic w_zf;
    logic w_lt;

    assign w_zf = i_cc[CC_ZF];
    assign w_lt = i_cc[CC_SF] ^ i_cc[CC_OF];

    always_comb begin
        o_cnd = 1'b0;
        case (i_ifun)
            C_YES:   o_cnd = 1'b1;
            C_LE:    o_cnd = w_lt | w_zf;
            C_L:     o_cnd = w_lt;
            C_E:     o_cnd = w_zf;
            C_NE:    o_cnd = ~w_zf;
            C_GE:    o_cnd = ~w_lt;
            C_G:     o_cnd = ~w_lt & ~w_zf;
            default: o_cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Execute-stage condition unit: CC register, condition evaluation, M-stage Cnd pipeline register.
// Optional macro COND_ILLEGAL_EN adds the registered illegal-function flag cnd_err.
module cond_unit
    import cond_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [CC_W-1:0] alu_cc,
    input  logic            set_cc,
    input  logic            exc_block,
    input  logic [3:0]      e_ifun,
    input  logic            e_stall,
    input  logic            e_bubble,
    output logic [CC_W-1:0] cc_q,
    output logic            e_cnd,
    output logic            m_cnd
`ifdef COND_ILLEGAL_EN
    ,
    output logic            cnd_err
`endif
);

    logic [CC_W-1:0] r_cc;
    logic            r_mCnd;
    logic            w_cnd;

    // A later-stage exception must not let a squashed OPq change architectural flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cc <= CC_RESET;
        end else if (set_cc && !exc_block) begin
            r_cc <= alu_cc;
        end
    end

    cond_eval u_eval (
        .i_cc   (r_cc),
        .i_ifun (e_ifun),
        .o_cnd  (w_cnd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mCnd <= 1'b0;
        end else if (e_bubble) begin
            r_mCnd <= 1'b0;
        end else if (!e_stall) begin
            r_mCnd <= w_cnd;
        end
    end

    assign cc_q  = r_cc;
    assign e_cnd = w_cnd;
    assign m_cnd = r_mCnd;

`ifdef COND_ILLEGAL_EN
    logic r_cndErr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cndErr <= 1'b0;
        end else if (e_bubble) begin
            r_cndErr <= 1'b0;
        end else if (!e_stall) begin
            r_cndErr <= (e_ifun > 4'd6);
        end
    end

    assign cnd_err = r_cndErr;
`endif

endmodule
